// File: rtl/pong_pkg.sv
// Shared geometry, reset positions and colour codes for the Pong pixel generator.
package pong_pkg;

  localparam logic [9:0] H_ACTIVE  = 10'd640;
  localparam logic [9:0] V_ACTIVE  = 10'd480;
  localparam logic [9:0] WALL_L    = 10'd32;
  localparam logic [9:0] WALL_R    = 10'd39;
  localparam logic [9:0] PAD_L     = 10'd600;
  localparam logic [9:0] PAD_R     = 10'd603;
  localparam logic [9:0] PAD_H     = 10'd72;
  localparam logic [9:0] PAD_STEP  = 10'd3;
  localparam logic [9:0] BALL_SIZE = 10'd8;
  localparam logic [9:0] BALL_STEP = 10'd2;

  localparam logic [9:0] PAD_TOP0    = 10'd204;
  localparam logic [9:0] PAD_TOP_MAX = V_ACTIVE - PAD_H;
  localparam logic [9:0] BALL_X0     = 10'd320;
  localparam logic [9:0] BALL_Y0     = 10'd240;

  typedef enum logic [2:0] {
    COL_BLACK = 3'b000,
    COL_BLUE  = 3'b001,
    COL_GREEN = 3'b010,
    COL_RED   = 3'b100
  } color_t;

  // Inclusive range test on raster coordinates.
  function automatic logic in_span(input logic [9:0] v, input logic [9:0] lo,
                                   input logic [9:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/pong_ball_ctrl.sv
// Ball position and direction, advanced once per frame tick with wall/edge/paddle bounces.
module pong_ball_ctrl
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [9:0] pad_top,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y
);

  logic       vx_neg, vy_neg;
  logic       vx_neg_nx, vy_neg_nx;
  logic [9:0] ball_r, ball_b, pad_bot;
  logic [9:0] x_nx, y_nx;
  logic       missed;

  assign ball_r  = ball_x + BALL_SIZE - 10'd1;
  assign ball_b  = ball_y + BALL_SIZE - 10'd1;
  assign pad_bot = pad_top + PAD_H - 10'd1;
  assign missed  = ball_x >= H_ACTIVE;

  // New direction comes from the current position; the step uses that new direction.
  always_comb begin
    vy_neg_nx = vy_neg;
    if (ball_y <= BALL_STEP) vy_neg_nx = 1'b0;
    if (ball_b >= V_ACTIVE - 10'd1 - BALL_STEP) vy_neg_nx = 1'b1;
    vx_neg_nx = vx_neg;
    if (ball_x <= WALL_R + BALL_STEP) vx_neg_nx = 1'b0;
    if (in_span(ball_r, PAD_L, PAD_R) && ball_b >= pad_top && ball_y <= pad_bot)
      vx_neg_nx = 1'b1;
    x_nx = vx_neg_nx ? ball_x - BALL_STEP : ball_x + BALL_STEP;
    y_nx = vy_neg_nx ? ball_y - BALL_STEP : ball_y + BALL_STEP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ball_x <= BALL_X0;
      ball_y <= BALL_Y0;
      vx_neg <= 1'b1;
      vy_neg <= 1'b0;
    end else if (tick) begin
      if (missed) begin
        ball_x <= BALL_X0;
        ball_y <= BALL_Y0;
        vx_neg <= 1'b1;
        vy_neg <= 1'b0;
      end else begin
        ball_x <= x_nx;
        ball_y <= y_nx;
        vx_neg <= vx_neg_nx;
        vy_neg <= vy_neg_nx;
      end
    end
  end

endmodule

// File: rtl/pong_pixel_generator.sv
// Pong game state (paddle, ball) updated once per frame, plus registered RGB colour per raster pixel.
module pong_pixel_generator
  import pong_pkg::*;
(
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_up_but,
  input  logic       i_down_but,
  input  logic       i_display_on,
  input  logic [9:0] i_h_spot,
  input  logic [9:0] i_v_spot,
  output logic [2:0] o_color
);

  logic       match, match_q, tick;
  logic [9:0] pad_top, ball_x, ball_y;
  color_t     color_nx;

  // Raster coordinates dwell for several clocks; edge-detect to get one tick per frame.
  assign match = (i_v_spot == V_ACTIVE + 10'd1) && (i_h_spot == 10'd0);
  assign tick  = match && !match_q;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) match_q <= 1'b0;
    else          match_q <= match;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      pad_top <= PAD_TOP0;
    end else if (tick) begin
      if (i_up_but && !i_down_but)
        pad_top <= (pad_top < PAD_STEP) ? 10'd0 : pad_top - PAD_STEP;
      else if (i_down_but && !i_up_but)
        pad_top <= (pad_top + PAD_STEP > PAD_TOP_MAX) ? PAD_TOP_MAX : pad_top + PAD_STEP;
    end
  end

  pong_ball_ctrl u_ball (
    .clk    (i_clock),
    .rst_n  (i_reset),
    .tick   (tick),
    .pad_top(pad_top),
    .ball_x (ball_x),
    .ball_y (ball_y)
  );

  always_comb begin
    color_nx = COL_BLACK;
    if (i_display_on) begin
      if (in_span(i_h_spot, WALL_L, WALL_R))
        color_nx = COL_BLUE;
      else if (in_span(i_h_spot, PAD_L, PAD_R) &&
               in_span(i_v_spot, pad_top, pad_top + PAD_H - 10'd1))
        color_nx = COL_GREEN;
      else if (in_span(i_h_spot, ball_x, ball_x + BALL_SIZE - 10'd1) &&
               in_span(i_v_spot, ball_y, ball_y + BALL_SIZE - 10'd1))
        color_nx = COL_RED;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) o_color <= COL_BLACK;
    else          o_color <= color_nx;
  end

endmodule

// File: tb/tb_pong_pixel_generator.sv
// Bench for pong_pixel_generator: frame-level game model checked against o_color every clock.
module tb_pong_pixel_generator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       up, down, disp;
  logic [9:0] hx, vy;
  logic [2:0] color;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  // model state: game quantities in plain integers, velocities signed
  int   m_pad, m_bx, m_by, m_vx, m_vy;
  bit   m_match, m_match_q, m_missed;
  logic [2:0] exp_color;

  pong_pixel_generator dut (
    .i_clock     (clk),
    .i_reset     (rst_n),
    .i_up_but    (up),
    .i_down_but  (down),
    .i_display_on(disp),
    .i_h_spot    (hx),
    .i_v_spot    (vy),
    .o_color     (color)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: o_color=%b expected %b (x=%0d y=%0d disp=%b) t=%0t",
                  name, act, exp, hx, vy, disp, $time);
  endtask

  function automatic logic [2:0] model_color(input int x, input int y, input bit d);
    if (!d) return 3'b000;
    if (x >= 32 && x <= 39) return 3'b001;
    if (x >= 600 && x <= 603 && y >= m_pad && y <= m_pad + 71) return 3'b010;
    if (x >= m_bx && x <= m_bx + 7 && y >= m_by && y <= m_by + 7) return 3'b100;
    return 3'b000;
  endfunction

  task automatic model_reset();
    m_pad = 204; m_bx = 320; m_by = 240; m_vx = -2; m_vy = 2;
    m_match_q = 1'b0;
  endtask

  task automatic model_tick(input bit u, input bit dn);
    int nvx, nvy;
    if (m_bx >= 640) begin
      m_bx = 320; m_by = 240; m_vx = -2; m_vy = 2;
      m_missed = 1'b1;
    end else begin
      nvy = m_vy;
      if (m_by <= 2) nvy = 2;
      if (m_by + 7 >= 477) nvy = -2;
      nvx = m_vx;
      if (m_bx <= 41) nvx = 2;
      if (m_bx + 7 >= 600 && m_bx + 7 <= 603 && m_by + 7 >= m_pad && m_by <= m_pad + 71)
        nvx = -2;
      m_vx = nvx; m_vy = nvy;
      m_bx = (m_bx + nvx) & 1023;
      m_by = (m_by + nvy) & 1023;
    end
    if (u && !dn)      m_pad = (m_pad < 3) ? 0 : m_pad - 3;
    else if (dn && !u) m_pad = (m_pad + 3 > 408) ? 408 : m_pad + 3;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
      exp_color = 3'b000;
    end else begin
      m_match   = (vy == 10'd481) && (hx == 10'd0);
      exp_color = model_color(int'(hx), int'(vy), disp);
      if (m_match && !m_match_q) model_tick(up, down);
      m_match_q = m_match;
    end
  end

  always @(posedge clk) begin
    #2;
    if (chk_en) cmp("model", color, exp_color);
  end

  task automatic drive(input int x, input int y, input bit d, input bit u, input bit dn);
    @(negedge clk);
    hx = 10'(x); vy = 10'(y); disp = d; up = u; down = dn;
  endtask

  task automatic do_tick(input bit u, input bit dn);
    repeat (4) drive(0, 481, 1'b0, u, dn);
    drive(1, 481, 1'b0, u, dn);
  endtask

  task automatic check_lit(input string name, input int x, input int y, input bit d,
                           input logic [2:0] exp);
    drive(x, y, d, up, down);
    @(posedge clk);
    #2;
    cmp(name, color, exp);
  endtask

  task automatic probe_random();
    int x, y;
    bit d;
    d = 1'b1;
    case ($urandom_range(0, 5))
      0, 1: begin
        x = m_bx + $urandom_range(0, 9) - 1;
        y = m_by + $urandom_range(0, 9) - 1;
      end
      2: begin
        x = $urandom_range(599, 604);
        y = m_pad + $urandom_range(0, 73) - 1;
      end
      3: begin
        x = $urandom_range(31, 40);
        y = $urandom_range(0, 479);
      end
      4: begin
        x = $urandom_range(0, 639);
        y = $urandom_range(0, 479);
      end
      default: begin
        x = m_bx + $urandom_range(0, 7);
        y = m_by + $urandom_range(0, 7);
        d = 1'b0;
      end
    endcase
    drive(x & 1023, y & 1023, d, up, down);
  endtask

  initial begin
    bit u, dn;
    hx = '0; vy = '0; disp = 1'b0; up = 1'b0; down = 1'b0;
    m_missed = 1'b0;
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // reset geometry
    check_lit("ball_centre", 320, 240, 1'b1, 3'b100);
    check_lit("wall", 35, 10, 1'b1, 3'b001);
    check_lit("paddle_top", 600, 204, 1'b1, 3'b010);
    check_lit("above_paddle", 600, 203, 1'b1, 3'b000);
    check_lit("display_off", 320, 240, 1'b0, 3'b000);

    // one tick from a 4-clock dwell
    do_tick(1'b0, 1'b0);
    check_lit("ball_moved_tl", 318, 242, 1'b1, 3'b100);
    check_lit("ball_moved_br", 325, 249, 1'b1, 3'b100);
    check_lit("ball_right_out", 326, 249, 1'b1, 3'b000);
    check_lit("ball_top_out", 320, 241, 1'b1, 3'b000);
    check_lit("ball_left_out", 317, 245, 1'b1, 3'b000);

    // paddle clamps at the top
    repeat (70) begin
      do_tick(1'b1, 1'b0);
      probe_random();
    end
    check_lit("pad_at_0", 600, 0, 1'b1, 3'b010);
    check_lit("pad_row71", 603, 71, 1'b1, 3'b010);
    check_lit("pad_row72", 603, 72, 1'b1, 3'b000);
    check_lit("wall_prio", 39, 0, 1'b1, 3'b001);

    // both buttons hold the paddle
    repeat (3) do_tick(1'b1, 1'b1);
    check_lit("both_hold_top", 600, 0, 1'b1, 3'b010);
    check_lit("both_hold_bot", 600, 72, 1'b1, 3'b000);

    // paddle clamps at the bottom; ball bounces off the wall meanwhile
    repeat (140) begin
      do_tick(1'b0, 1'b1);
      probe_random();
    end
    check_lit("pad_at_408", 601, 408, 1'b1, 3'b010);
    check_lit("pad_row479", 601, 479, 1'b1, 3'b010);
    check_lit("pad_row407", 601, 407, 1'b1, 3'b000);

    // paddle tracks the ball: paddle bounces
    repeat (600) begin
      u = (m_pad + 36 > m_by + 6);
      dn = (m_pad + 36 < m_by + 2);
      if ($urandom_range(0, 7) == 0) begin
        u = 1'($urandom_range(0, 1));
        dn = 1'($urandom_range(0, 1));
      end
      m_missed = 1'b0;
      do_tick(u, dn);
      repeat (6) probe_random();
      if (m_missed) check_lit("miss_recentre", 320, 240, 1'b1, 3'b100);
    end

    // random buttons: misses and recentring, with one mid-frame reset
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        drive(123, 300, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        drive(0, 481, 1'b0, 1'b0, 1'b0);
        drive(5, 100, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        check_lit("rst_ball", 320, 240, 1'b1, 3'b100);
        check_lit("rst_pad", 600, 204, 1'b1, 3'b010);
        check_lit("rst_pad_bot", 600, 276, 1'b1, 3'b000);
      end
      m_missed = 1'b0;
      do_tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat (6) probe_random();
      if (m_missed) check_lit("miss_recentre", 320, 240, 1'b1, 3'b100);
    end

    drive(10, 10, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
